// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST sequencer and its LFSR.
package adder_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_RUN    = 3'd2,
        ST_SETTLE = 3'd3,
        ST_CHECK  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'd1;

    // Right-shift Galois step; mask bit 0 is the feedback bit itself, so the taps land on bits [31:1].
    function automatic logic [31:0] lfsr_next(input logic [31:0] x);
        return {1'b0, x[31:1]} ^ ({32{x[0]}} & {LFSR_TAPS[31:1], 1'b0});
    endfunction

endpackage

// File: rtl/adder_bist_lfsr.sv
// 32-bit Galois LFSR: seed load (zero replaced by the default seed) and a two-step advance per step pulse.
module adder_bist_lfsr
    import adder_bist_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    output logic [31:0] value,
    output logic [31:0] value_next
);

    assign value_next = lfsr_next(value);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED_DEF;
        end else if (load) begin
            value <= (seed == '0) ? LFSR_SEED_DEF : seed;
        end else if (step) begin
            value <= lfsr_next(value_next);
        end
    end

endmodule

// File: rtl/adder_bist_sequencer.sv
// BIST initiator for the instrumented adder: drives random operands, checks sums, tracks errors and ring counts.
// Optional: define ADDER_BIST_HALT_ON_FAIL_EN to end the campaign at the first mismatching vector.
module adder_bist_sequencer
    import adder_bist_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int RUN_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             adder_run,
    input  logic [WIDTH-1:0] sum_in,
    input  logic [WIDTH-1:0] ring_count_in,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_fail_idx,
    output logic [WIDTH-1:0] max_ring
);

    localparam logic [2:0] IDLE   = ST_IDLE;
    localparam logic [2:0] LOAD   = ST_LOAD;
    localparam logic [2:0] RUN    = ST_RUN;
    localparam logic [2:0] SETTLE = ST_SETTLE;
    localparam logic [2:0] CHECK  = ST_CHECK;
    localparam logic [2:0] FINISH = ST_FINISH;

    localparam int CYC_MAX = (RUN_CYCLES > SETTLE_CYCLES) ? RUN_CYCLES : SETTLE_CYCLES;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    logic [2:0]       state;
    logic [CYC_W-1:0] cyc;
    logic [CNT_W-1:0] num_lat;
    logic [CNT_W-1:0] vec_next;
    logic [WIDTH-1:0] sum_ref;
    logic [31:0]      lfsr_val;
    logic [31:0]      lfsr_nxt;
    logic             start_ok;
    logic             mismatch;
    logic             halt;

    assign start_ok  = (state == IDLE) && start;
    assign adder_run = (state == RUN);
    assign sum_ref   = a_out + b_out;
    assign mismatch  = (sum_in != sum_ref);
    assign vec_next  = vec_count + CNT_W'(1);

`ifdef ADDER_BIST_HALT_ON_FAIL_EN
    assign halt = mismatch;
`else
    assign halt = 1'b0;
`endif

    adder_bist_lfsr u_lfsr (
        .clk        (wb_clk_i),
        .rst_n      (wb_rst_ni),
        .load       (start_ok),
        .seed       (32'(seed)),
        .step       (state == LOAD),
        .value      (lfsr_val),
        .value_next (lfsr_nxt)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state          <= IDLE;
            cyc            <= '0;
            num_lat        <= '0;
            a_out          <= '0;
            b_out          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            vec_count      <= '0;
            err_count      <= '0;
            first_fail_idx <= '0;
            max_ring       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        num_lat        <= num_vectors;
                        vec_count      <= '0;
                        err_count      <= '0;
                        first_fail_idx <= '0;
                        max_ring       <= '0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= (num_vectors == '0) ? FINISH : LOAD;
                    end
                end
                LOAD: begin
                    a_out <= WIDTH'(lfsr_val);
                    b_out <= WIDTH'(lfsr_nxt);
                    cyc   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    if (cyc == CYC_W'(RUN_CYCLES - 1)) begin
                        cyc   <= '0;
                        state <= SETTLE;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                SETTLE: begin
                    if (cyc == CYC_W'(SETTLE_CYCLES - 1)) begin
                        cyc   <= '0;
                        state <= CHECK;
                    end else begin
                        cyc <= cyc + CYC_W'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) err_count <= err_count + CNT_W'(1);
                        if (err_count == '0) first_fail_idx <= vec_count;
                    end
                    if (ring_count_in > max_ring) max_ring <= ring_count_in;
                    vec_count <= vec_next;
                    state     <= (vec_next == num_lat || halt) ? FINISH : LOAD;
                end
                FINISH: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_sequencer.sv
// Self-checking bench for adder_bist_sequencer; honours ADDER_BIST_HALT_ON_FAIL_EN when defined.
module tb_adder_bist_sequencer;

    localparam int W   = 32;
    localparam int CW  = 16;
    localparam int RUN = 16;
    localparam int SET = 2;
    localparam int VEC_LAT = 1 + RUN + SET + 1;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_ni = 1'b0;
    logic          start = 1'b0;
    logic [CW-1:0] num_vectors = '0;
    logic [W-1:0]  seed = '0;
    logic [W-1:0]  a_out, b_out, sum_in, ring_count_in, max_ring;
    logic          adder_run, busy, done;
    logic [CW-1:0] vec_count, err_count, first_fail_idx;

    int checks = 0;
    int fails  = 0;

    logic [2*W-1:0] exp_ops[$];

    // Bench-side vector tracking drives the adder model (fault injection, ring counts)
    int       run_edges = 0;
    int       base = 0;
    logic     run_q = 1'b0;
    logic     fault_en = 1'b0;
    int       fault_vec = 0;
    logic [W-1:0] ring_tab [16];
    int       vi;

    always #5 wb_clk_i = ~wb_clk_i;

    always @(posedge wb_clk_i) begin
        run_q <= adder_run;
        if (adder_run && !run_q) run_edges <= run_edges + 1;
    end

    assign vi            = run_edges - base;
    assign sum_in        = (a_out + b_out) ^ ((fault_en && vi == fault_vec) ? W'(1) : W'(0));
    assign ring_count_in = (vi >= 1 && vi <= 16) ? ring_tab[vi-1] : '0;

    adder_bist_sequencer #(
        .WIDTH(W), .RUN_CYCLES(RUN), .SETTLE_CYCLES(SET), .CNT_W(CW)
    ) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni), .start(start),
        .num_vectors(num_vectors), .seed(seed),
        .a_out(a_out), .b_out(b_out), .adder_run(adder_run),
        .sum_in(sum_in), .ring_count_in(ring_count_in),
        .busy(busy), .done(done), .vec_count(vec_count), .err_count(err_count),
        .first_fail_idx(first_fail_idx), .max_ring(max_ring)
    );

    function automatic logic [31:0] model_step(input logic [31:0] x);
        logic fb;
        fb = x[0];
        x  = x >> 1;
        if (fb) x = x ^ 32'h8020_0002;
        return x;
    endfunction

    function automatic logic [2*W-1:0] model_pair(input logic [W-1:0] s, input int idx);
        logic [31:0] l;
        l = (s == '0) ? 32'd1 : s;
        for (int i = 0; i < idx; i++) l = model_step(model_step(l));
        return {l, model_step(l)};
    endfunction

    // Starts a campaign, scoreboards every operand pair at adder_run rise, and waits (bounded) for done.
    task automatic run_campaign(input logic [CW-1:0] n, input logic [W-1:0] s, input int inject_at,
                                output int run_cyc, output int busy_cyc, output logic [W-1:0] first_max);
        logic prev;
        logic [2*W-1:0] e;
        exp_ops.delete();
        for (int i = 0; i < int'(n); i++) exp_ops.push_back(model_pair(s, i));
        @(negedge wb_clk_i);
        num_vectors = n; seed = s; start = 1'b1; base = run_edges;
        @(negedge wb_clk_i);
        start = 1'b0;
        first_max = max_ring;
        run_cyc = 0; busy_cyc = 0; prev = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (done) break;
            if (c == inject_at) begin
                start = 1'b1; seed = 32'hDEAD_BEEF; num_vectors = 1;
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cyc++;
            if (adder_run) run_cyc++;
            if (adder_run && !prev) begin
                checks++;
                if (exp_ops.size() == 0) begin
                    fails++;
                    $display("FAIL scoreboard_underflow: a=%h b=%h with no expected pair", a_out, b_out);
                end else begin
                    e = exp_ops.pop_front();
                    if ({a_out, b_out} !== e) begin
                        fails++;
                        $display("FAIL operands: got a=%h b=%h expected a=%h b=%h",
                                 a_out, b_out, e[2*W-1:W], e[W-1:0]);
                    end
                end
            end
            prev = adder_run;
            @(negedge wb_clk_i);
        end
        start = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL campaign_timeout: done=%b expected 1", done);
        end
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        checks++;
        if ({a_out, b_out, adder_run, busy, done} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: a=%h b=%h run=%b busy=%b done=%b expected all 0",
                     a_out, b_out, adder_run, busy, done);
        end
        checks++;
        if ({vec_count, err_count, first_fail_idx, max_ring} !== '0) begin
            fails++;
            $display("FAIL reset_counters: vec=%0d err=%0d ffi=%0d max=%0d expected 0",
                     vec_count, err_count, first_fail_idx, max_ring);
        end
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
    endtask

    task automatic test_single_vector();
        int rc, bc;
        logic [W-1:0] fm;
        run_campaign(1, 32'd1, -1, rc, bc, fm);
        checks++;
        if (a_out !== 32'h0000_0001 || b_out !== 32'h8020_0002) begin
            fails++;
            $display("FAIL first_operands: a=%h b=%h expected 00000001 80200002", a_out, b_out);
        end
        checks++;
        if (rc != RUN) begin fails++; $display("FAIL run_width: got %0d expected %0d", rc, RUN); end
        checks++;
        if (bc != VEC_LAT + 1) begin fails++; $display("FAIL busy_span: got %0d expected %0d", bc, VEC_LAT + 1); end
        checks++;
        if (vec_count !== 1 || err_count !== 0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL single_counts: vec=%0d err=%0d busy=%b expected 1 0 0", vec_count, err_count, busy);
        end
    endtask

    task automatic test_zero_vectors();
        int rc, bc;
        logic [W-1:0] fm;
        run_campaign(0, 32'h55, -1, rc, bc, fm);
        checks++;
        if (bc != 1 || rc != 0) begin
            fails++;
            $display("FAIL zero_vectors_timing: busy=%0d run=%0d expected 1 0", bc, rc);
        end
        checks++;
        if (done !== 1'b1 || vec_count !== 0) begin
            fails++;
            $display("FAIL zero_vectors_state: done=%b vec=%0d expected 1 0", done, vec_count);
        end
    endtask

    task automatic test_fault();
        int rc, bc;
        logic [W-1:0] fm;
        logic [2*W-1:0] bad;
        bad = model_pair(32'h0BAD_F00D, 2);
        fault_en = 1'b1; fault_vec = 3;
        run_campaign(10, 32'h0BAD_F00D, -1, rc, bc, fm);
        fault_en = 1'b0;
        checks++;
        if (err_count !== 1 || first_fail_idx !== 2) begin
            fails++;
            $display("FAIL fault_errs: err=%0d ffi=%0d expected 1 2", err_count, first_fail_idx);
        end
`ifdef ADDER_BIST_HALT_ON_FAIL_EN
        checks++;
        if (vec_count !== 3 || done !== 1'b1) begin
            fails++;
            $display("FAIL halt_vec: vec=%0d done=%b expected 3 1", vec_count, done);
        end
        checks++;
        if ({a_out, b_out} !== bad) begin
            fails++;
            $display("FAIL halt_operands: got %h expected %h", {a_out, b_out}, bad);
        end
`else
        checks++;
        if (vec_count !== 10 || bad == '0) begin
            fails++;
            $display("FAIL fault_vec: vec=%0d expected 10", vec_count);
        end
`endif
    endtask

    task automatic test_max_ring();
        int rc, bc;
        logic [W-1:0] fm;
        ring_tab[0] = 100; ring_tab[1] = 250; ring_tab[2] = 7;
        run_campaign(3, 32'hCAFE_0001, -1, rc, bc, fm);
        checks++;
        if (max_ring !== 250) begin fails++; $display("FAIL max_ring: got %0d expected 250", max_ring); end
        ring_tab[0] = 3;
        run_campaign(1, 32'hCAFE_0002, -1, rc, bc, fm);
        checks++;
        if (fm !== 0) begin fails++; $display("FAIL max_ring_clear: got %0d expected 0", fm); end
        checks++;
        if (max_ring !== 3) begin fails++; $display("FAIL max_ring_second: got %0d expected 3", max_ring); end
        for (int i = 0; i < 16; i++) ring_tab[i] = '0;
    endtask

    task automatic test_start_while_busy();
        int rc, bc;
        logic [W-1:0] fm;
        run_campaign(2, 32'h1234_5678, 5, rc, bc, fm);
        checks++;
        if (vec_count !== 2 || bc != 2 * VEC_LAT + 1 || exp_ops.size() != 0) begin
            fails++;
            $display("FAIL start_while_busy: vec=%0d busy=%0d left=%0d expected 2 %0d 0",
                     vec_count, bc, exp_ops.size(), 2 * VEC_LAT + 1);
        end
    endtask

    task automatic test_reset_mid_run();
        int rises;
        logic prev;
        exp_ops.delete();
        @(negedge wb_clk_i);
        num_vectors = 10; seed = 32'h0000_0777; start = 1'b1;
        @(negedge wb_clk_i);
        start = 1'b0;
        rises = 0; prev = 1'b0;
        for (int c = 0; c < 1000 && rises < 5; c++) begin
            if (adder_run && !prev) rises++;
            prev = adder_run;
            if (rises < 5) @(negedge wb_clk_i);
        end
        repeat (3) @(negedge wb_clk_i);
        checks++;
        if (adder_run !== 1'b1 || vec_count !== 4) begin
            fails++;
            $display("FAIL pre_reset: run=%b vec=%0d expected 1 4", adder_run, vec_count);
        end
        wb_rst_ni = 1'b0;
        #1;
        checks++;
        if ({adder_run, busy, done} !== 3'b000) begin
            fails++;
            $display("FAIL async_reset_ctrl: run=%b busy=%b done=%b expected 0 0 0", adder_run, busy, done);
        end
        checks++;
        if ({vec_count, err_count, first_fail_idx, max_ring} !== '0) begin
            fails++;
            $display("FAIL async_reset_counters: vec=%0d err=%0d ffi=%0d max=%0d expected 0",
                     vec_count, err_count, first_fail_idx, max_ring);
        end
        @(negedge wb_clk_i);
        wb_rst_ni = 1'b1;
        @(negedge wb_clk_i);
    endtask

    task automatic test_seed_zero();
        int rc, bc;
        logic [W-1:0] fm;
        run_campaign(3, 32'd0, -1, rc, bc, fm);
        checks++;
        if ({a_out, b_out} !== model_pair(32'd1, 2)) begin
            fails++;
            $display("FAIL seed_zero: got %h expected %h", {a_out, b_out}, model_pair(32'd1, 2));
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) ring_tab[i] = '0;
        test_reset();
        test_single_vector();
        test_zero_vectors();
        test_fault();
        test_max_ring();
        test_start_while_busy();
        test_reset_mid_run();
        test_seed_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/adder_bist_sequencer.md
Name: adder_bist_sequencer

Overview:
On-chip initiator for the instrumented adder wrapper. It generates pseudo-random operand pairs and drives them with a run strobe into the adder's operand and run inputs. After each run it reads back the sum and ring-oscillator count and checks the sum against an internally computed reference. It accumulates error count, vector count and worst-case ring count for readout over the logic-analyser bank.

Parameters:
WIDTH, 32, operand/sum/ring-count width
RUN_CYCLES, 16, cycles adder_run held high per vector (>=1)
SETTLE_CYCLES, 2, cycles after run falls before sampling sum_in/ring_count_in (>=1)
CNT_W, 16, width of vector and error counters

Ports:
wb_clk_i  in  1  clock
wb_rst_ni  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; starts a campaign, ignored while busy
num_vectors  in  CNT_W  vectors per campaign; 0 = campaign completes immediately
seed  in  WIDTH  LFSR seed, sampled on start; 0 replaced by 1
a_out  out  WIDTH  operand A to adder
b_out  out  WIDTH  operand B to adder
adder_run  out  1  run/enable to instrumented adder (gates ring oscillator)
sum_in  in  WIDTH  adder sum (mod 2^WIDTH)
ring_count_in  in  WIDTH  ring-oscillator count captured by adder
busy  out  1  campaign in progress
done  out  1  sticky; set on campaign end, cleared by next accepted start
vec_count  out  CNT_W  vectors checked this campaign
err_count  out  CNT_W  mismatches, saturating at all-ones
first_fail_idx  out  CNT_W  vec_count value at first mismatch; valid when err_count != 0
max_ring  out  WIDTH  largest ring_count_in sampled this campaign

Behaviour:
- Reset: all outputs 0; FSM in IDLE; LFSR = 1.
- FSM states: IDLE, LOAD, RUN, SETTLE, CHECK, FINISH.
- IDLE: on start, latch num_vectors and seed (0->1) and clear vec_count, err_count, first_fail_idx, max_ring and done. Set busy. Go to LOAD, or to FINISH if num_vectors==0.
- LOAD (1 cycle): a_out <= lfsr, b_out <= lfsr stepped once; LFSR advances two steps. Go to RUN.
- RUN: adder_run=1 for exactly RUN_CYCLES cycles, starting the cycle after LOAD. a_out/b_out stable throughout.
- SETTLE: adder_run=0 for SETTLE_CYCLES cycles.
- CHECK (1 cycle):
  - Compare sum_in against (a_out+b_out) truncated to WIDTH.
  - On mismatch: err_count++ (saturating). If err_count was 0, first_fail_idx <= vec_count.
  - max_ring <= max(max_ring, ring_count_in), unsigned.
  - vec_count++.
  - If the new vec_count == latched num_vectors, go to FINISH; otherwise go to LOAD.
- FINISH (1 cycle): busy<=0, done<=1; go to IDLE.
- Per-vector latency: 1 + RUN_CYCLES + SETTLE_CYCLES + 1 cycles.
- LFSR: 32-bit Galois, right-shift, tap mask 32'h8020_0003. WIDTH<32 uses the low bits.
- start while busy: ignored. Changes to num_vectors/seed mid-campaign: no effect.
- Async reset mid-run: adder_run drops immediately; all counters cleared; done=0.
- start in the FINISH cycle: ignored. start is accepted only in IDLE.

Optional Feature:
ADDER_BIST_HALT_ON_FAIL_EN
- Defined: the first mismatch in CHECK goes to FINISH instead of LOAD. vec_count includes the failing vector. a_out/b_out hold the failing operands until the next start.
- Undefined: the campaign always runs all num_vectors.

Decomposition:
- Package adder_bist_pkg holds:
  - state enum typedef
  - LFSR tap constant LFSR_TAPS = 32'h8020_0003
  - nonzero-seed default LFSR_SEED_DEF = 1
- Sub-module adder_bist_lfsr: Galois LFSR with load/seed and step enable, two steps per enable pulse.

Test Plan:
- Reset, then start with seed=1, num_vectors=1, sum_in modelled as a correct adder. Expect: first operands a_out=32'h0000_0001, b_out=32'h8020_0002. adder_run high 16 cycles. done after 20 cycles from LOAD. vec_count=1, err_count=0.
- num_vectors=0, start -> busy high 1 cycle, done=1, vec_count=0, adder_run never asserted.
- Faulty adder model (sum bit 0 inverted on the 3rd vector only), num_vectors=10 -> err_count=1, first_fail_idx=2, vec_count=10. With ADDER_BIST_HALT_ON_FAIL_EN: vec_count=3 and done set.
- ring_count_in driven 100, 250, 7 on successive vectors, num_vectors=3 -> max_ring=250. A second start clears max_ring to 0 before its first CHECK.
- Assert wb_rst_ni low during RUN of vector 5 -> adder_run, busy, done and all counters 0 immediately. start pulse while busy is ignored (vec_count unaffected, no restart).
- seed=0 -> behaves identically to seed=1 (same a_out/b_out sequence).
